// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor control path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: opcode constants, FSM state encoding, bus-select codes and small
// helpers used by both the control top level and the decode map.
package cpu_pkg;

  // Opcodes, IR[15:13]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_X111 = 3'b111;  // halt or nop, depending on build

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_FWAIT  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EX1    = 3'd4,
    ST_EX2    = 3'd5,
    ST_EX3    = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // Bus sources above the general registers (0-6 select R0-R6)
  localparam logic [3:0] SEL_PC  = 4'd7;
  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  // One-hot write enable for register index 0-7 (7 is the PC)
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  // Bus select code for a register field of the IR
  function automatic logic [3:0] sel_reg(input logic [2:0] idx);
    return {1'b0, idx};
  endfunction

  // Opcodes whose EX2 waits for a memory read to return
  function automatic logic is_mem_wait_op(input logic [2:0] op);
    return (op == OP_MVI) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Control decode: maps (state, opcode, rX, rY, GNZ) to datapath control lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs every cycle.
//
// Ports: state (current FSM state), opcode/rx/ry (IR fields), gnz (G non-zero);
// outputs bus_sel, reg_in[7:0], incr_pc, a_in, g_in, add_sub, addr_in,
// dout_in, w_d, done, halted. Unlisted outputs of a state are 0.
// Build option CTRL_HALT_EN: when defined, the HALT state drives halted=1.
module control_decode
  import cpu_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] opcode,
  input  logic [2:0] rx,
  input  logic [2:0] ry,
  input  logic       gnz,
  output logic [3:0] bus_sel,
  output logic [7:0] reg_in,
  output logic       incr_pc,
  output logic       a_in,
  output logic       g_in,
  output logic       add_sub,
  output logic       addr_in,
  output logic       dout_in,
  output logic       w_d,
  output logic       done,
  output logic       halted
);

  always_comb begin
    bus_sel = 4'd0;
    reg_in  = 8'd0;
    incr_pc = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    done    = 1'b0;
    halted  = 1'b0;

    case (state_t'(state))
      ST_FETCH: begin
        bus_sel = SEL_PC;
        addr_in = 1'b1;
        incr_pc = 1'b1;
      end

      ST_EX1: begin
        case (opcode)
          OP_MV: begin
            bus_sel = sel_reg(ry);
            reg_in  = reg_onehot(rx);
            done    = 1'b1;
          end
          OP_MVI: begin
            // Point the address register at the immediate word
            bus_sel = SEL_PC;
            addr_in = 1'b1;
            incr_pc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = sel_reg(rx);
            a_in    = 1'b1;
          end
          OP_LD, OP_ST: begin
            bus_sel = sel_reg(ry);
            addr_in = 1'b1;
          end
          OP_MVNZ: begin
            // Bus is driven either way; only the write is conditional
            bus_sel = sel_reg(ry);
            if (gnz) begin
              reg_in = reg_onehot(rx);
            end
            done    = 1'b1;
          end
          default: begin
            // 111: halt or nop, both complete in this cycle
            done = 1'b1;
          end
        endcase
      end

      ST_EX2: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            bus_sel = sel_reg(ry);
            g_in    = 1'b1;
            add_sub = opcode[0];
          end
          OP_ST: begin
            bus_sel = sel_reg(rx);
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          default: begin
            // mvi/ld wait for memory; nothing driven
          end
        endcase
      end

      ST_EX3: begin
        case (opcode)
          OP_MVI, OP_LD: begin
            bus_sel = SEL_DIN;
            reg_in  = reg_onehot(rx);
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = SEL_G;
            reg_in  = reg_onehot(rx);
            done    = 1'b1;
          end
          default: begin
          end
        endcase
      end

`ifdef CTRL_HALT_EN
      ST_HALT: begin
        halted = 1'b1;
      end
`endif

      default: begin
        // IDLE, FWAIT, DECODE: all outputs low
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: owns the IR and sequences fetch/decode/execute.
// Latency: fetch 2+MEM_LAT cycles; execute 1 (mv/mvnz/111), 2 (st),
//          3 (add/sub), 2+MEM_LAT (ld/mvi). Done pulses in the last cycle.
// Backpressure: Run is sampled only in IDLE and in the Done cycle; a running
//          instruction always completes unless Resetn falls.
//
// Ports: Clock, Resetn (async active-low), Run, DIN (memory read data),
// GNZ (G non-zero); outputs BusSel, RegIn[7:0] (bit 7 = PC load), IncrPc,
// Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done, Halted.
// Build option CTRL_HALT_EN: opcode 111 halts until reset; otherwise it is a
// nop and Halted stays 0.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              GNZ,
  output logic [3:0]        BusSel,
  output logic [7:0]        RegIn,
  output logic              IncrPc,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              ADDRin,
  output logic              DOUTin,
  output logic              W_D,
  output logic              Done,
  output logic              Halted
);

  // Wait counter counts down to zero, so it is loaded with MEM_LAT-1
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [1:0]        wait_q, wait_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       unused_ir_bits;

  assign opcode = ir_q[DATA_W-1 -: 3];
  assign rx     = ir_q[DATA_W-4 -: 3];
  assign ry     = ir_q[DATA_W-7 -: 3];
  // Low IR bits carry no control information
  assign unused_ir_bits = ^ir_q[DATA_W-10:0];

  // Outputs are a pure function of state and IR, so an asynchronous reset
  // into IDLE drops every enable immediately.
  control_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .rx      (rx),
    .ry      (ry),
    .gnz     (GNZ),
    .bus_sel (BusSel),
    .reg_in  (RegIn),
    .incr_pc (IncrPc),
    .a_in    (Ain),
    .g_in    (Gin),
    .add_sub (AddSub),
    .addr_in (ADDRin),
    .dout_in (DOUTin),
    .w_d     (W_D),
    .done    (Done),
    .halted  (Halted)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_FWAIT;
        wait_d  = WAIT_INIT;
      end
      ST_FWAIT: begin
        if (wait_q == 2'd0) begin
          state_d = ST_DECODE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_DECODE: begin
        ir_d    = DIN;
        state_d = ST_EX1;
      end
      ST_EX1: begin
        // Single-cycle opcodes leave through the Done override below
        state_d = ST_EX2;
        wait_d  = WAIT_INIT;
      end
      ST_EX2: begin
        if (!is_mem_wait_op(opcode) || (wait_q == 2'd0)) begin
          state_d = ST_EX3;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_EX3: begin
        state_d = ST_IDLE;
      end
`ifdef CTRL_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The Done cycle is the only point mid-run where Run is looked at
    if (Done) begin
      state_d = Run ? ST_FETCH : ST_IDLE;
`ifdef CTRL_HALT_EN
      if ((state_q == ST_EX1) && (opcode == OP_X111)) begin
        state_d = ST_HALT;
      end
`endif
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int MEM_LAT = 1;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        GNZ;
  logic [3:0]  BusSel;
  logic [7:0]  RegIn;
  logic        IncrPc, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done, Halted;

  multicycle_control #(.DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .GNZ    (GNZ),
    .BusSel (BusSel),
    .RegIn  (RegIn),
    .IncrPc (IncrPc),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .ADDRin (ADDRin),
    .DOUTin (DOUTin),
    .W_D    (W_D),
    .Done   (Done),
    .Halted (Halted)
  );

  always #5 Clock = ~Clock;

  // Control vector as observed on the DUT outputs
  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] regin;
    logic [7:0] flags;   // incr, ain, gin, sub, addr, dout, wd, done
    logic       halted;
  } ctl_t;

  localparam logic [7:0] F_INCR = 8'h80, F_AIN = 8'h40, F_GIN = 8'h20, F_SUB = 8'h10;
  localparam logic [7:0] F_ADDR = 8'h08, F_DOUT = 8'h04, F_WD = 8'h02, F_DONE = 8'h01;

  typedef struct {
    ctl_t v;
    int   gap;   // idle cycles expected before this vector; -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ctl_t mk(input logic [3:0] sel, input logic [7:0] regin, input logic [7:0] flags);
    ctl_t c;
    c.sel = sel; c.regin = regin; c.flags = flags; c.halted = 1'b0;
    return c;
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.sel    = BusSel;
    c.regin  = RegIn;
    c.flags  = {IncrPc, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done};
    c.halted = Halted;
    return c;
  endfunction

  task automatic push(input ctl_t v, input int gap);
    exp_t e;
    e.v = v; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // ---------------- environment: datapath + program memory ----------------
  logic [15:0] img   [0:255];   // image loaded into memory at reset
  logic [15:0] mem   [0:255];
  logic [15:0] env_r [0:7];     // R0-R6, PC
  logic [15:0] env_a, env_g, env_addr, env_din, bus;

  assign DIN = env_din;
  assign GNZ = (env_g != 16'd0);

  always_comb begin
    if (BusSel < 4'd8)       bus = env_r[BusSel[2:0]];
    else if (BusSel == 4'd8) bus = env_g;
    else if (BusSel == 4'd9) bus = env_din;
    else                     bus = 16'd0;
  end

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) env_r[i] <= 16'd0;
      env_a <= 16'd0; env_g <= 16'd0; env_addr <= 16'd0; env_din <= 16'd0;
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else begin
      for (int i = 0; i < 8; i++) if (RegIn[i]) env_r[i] <= bus;
      if (IncrPc && !RegIn[7]) env_r[7] <= env_r[7] + 16'd1;
      if (Ain)    env_a    <= bus;
      if (Gin)    env_g    <= AddSub ? env_a - bus : env_a + bus;
      if (ADDRin) env_addr <= bus;
      if (W_D)    mem[env_addr[7:0]] <= bus;
      env_din <= mem[env_addr[7:0]];
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [15:0] mdl_r [0:7];
  logic [15:0] mdl_m [0:255];

  task automatic model_run(input int n, output int executed);
    logic [15:0] w, a, g;
    logic [2:0]  op, x, y;
    logic        stop;
    int          l;
    l = MEM_LAT;
    for (int i = 0; i < 8; i++) mdl_r[i] = 16'd0;
    for (int i = 0; i < 256; i++) mdl_m[i] = img[i];
    a = 16'd0; g = 16'd0; stop = 1'b0; executed = 0;
    for (int k = 0; k < n && !stop; k++) begin
      w = mdl_m[mdl_r[7][7:0]];
      push(mk(4'd7, 8'h00, F_INCR | F_ADDR), (k == 0) ? -1 : 0);
      mdl_r[7] = mdl_r[7] + 16'd1;
      op = w[15:13]; x = w[12:10]; y = w[9:7];
      case (op)
        3'd0: begin
          push(mk({1'b0, y}, oh(x), F_DONE), l + 1);
          mdl_r[x] = mdl_r[y];
        end
        3'd1: begin
          push(mk(4'd7, 8'h00, F_INCR | F_ADDR), l + 1);
          w = mdl_m[mdl_r[7][7:0]];
          mdl_r[7] = mdl_r[7] + 16'd1;
          push(mk(4'd9, oh(x), F_DONE), l);
          mdl_r[x] = w;
        end
        3'd2, 3'd3: begin
          push(mk({1'b0, x}, 8'h00, F_AIN), l + 1);
          a = mdl_r[x];
          push(mk({1'b0, y}, 8'h00, F_GIN | (op[0] ? F_SUB : 8'h00)), 0);
          g = op[0] ? a - mdl_r[y] : a + mdl_r[y];
          push(mk(4'd8, oh(x), F_DONE), 0);
          mdl_r[x] = g;
        end
        3'd4: begin
          push(mk({1'b0, y}, 8'h00, F_ADDR), l + 1);
          push(mk(4'd9, oh(x), F_DONE), l);
          mdl_r[x] = mdl_m[mdl_r[y][7:0]];
        end
        3'd5: begin
          push(mk({1'b0, y}, 8'h00, F_ADDR), l + 1);
          push(mk({1'b0, x}, 8'h00, F_DOUT | F_WD | F_DONE), 0);
          mdl_m[mdl_r[y][7:0]] = mdl_r[x];
        end
        3'd6: begin
          push(mk({1'b0, y}, (g != 16'd0) ? oh(x) : 8'h00, F_DONE), l + 1);
          if (g != 16'd0) mdl_r[x] = mdl_r[y];
        end
        default: begin
          push(mk(4'd0, 8'h00, F_DONE), l + 1);
`ifdef CTRL_HALT_EN
          stop = 1'b1;
`endif
        end
      endcase
      executed++;
    end
  endtask

  // ---------------- monitor: pops and compares on every active cycle ----------------
  logic mon_en = 1'b0;
  int   zero_run = 0;
  ctl_t mon_v, mon_nh;
  exp_t mon_e;

  always @(negedge Clock) begin
    if (!mon_en) begin
      zero_run = 0;
    end else begin
      mon_v = sample();
      mon_nh = mon_v;
      mon_nh.halted = 1'b0;
      if (mon_nh != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ctl got=%h want=nothing", mon_v);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_v !== mon_e.v) begin
            errors++;
            $display("FAIL ctl_vector got=%h want=%h", mon_v, mon_e.v);
          end
          if (mon_e.gap >= 0) begin
            checks++;
            if (zero_run != mon_e.gap) begin
              errors++;
              $display("FAIL ctl_timing idle_cycles got=%0d want=%0d", zero_run, mon_e.gap);
            end
          end
        end
        zero_run = 0;
      end else begin
        zero_run++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_burst(input string name, input int n);
    int exec, seen, cyc;
    mon_en = 1'b0; Run = 1'b0; Resetn = 1'b0;
    exp_q.delete();
    model_run(n, exec);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge Clock);
    Run = 1'b1;
    seen = 0; cyc = 0;
    while (seen < exec && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      if (Done) seen++;
    end
    Run = 1'b0;
    checks++;
    if (seen != exec) begin
      errors++;
      $display("FAIL %s done_count got=%0d want=%0d", name, seen, exec);
    end
    repeat (6) @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_expected got=%0d want=0", name, exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (env_r[i] !== mdl_r[i]) begin
        errors++;
        $display("FAIL %s reg%0d got=%h want=%h", name, i, env_r[i], mdl_r[i]);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'd0;
  endtask

  initial begin
    int   cyc, bad;
    ctl_t v;
    Run = 1'b0;
    Resetn = 1'b1;
    clear_img();
    #2 Resetn = 1'b0;
    #1;
    v = sample();
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", v, ctl_t'('0));
    end

    // Directed program: mvi, add, sub, mvnz (G!=0), st, mv to PC
    clear_img();
    img[0] = 16'h2480; img[1] = 16'h0005; img[2] = 16'h4500; img[3] = 16'h6500;
    img[4] = 16'hCE00; img[5] = 16'hA280; img[6] = 16'h1D00;
    run_burst("directed", 7);

    // mvnz with G still zero after reset: no write
    clear_img();
    img[0] = 16'hCE00;
    run_burst("mvnz_g0", 1);

    // Opcode 111 followed by mvi
    clear_img();
    img[0] = 16'hE000; img[1] = 16'h2480; img[2] = 16'h0005;
    run_burst("op111", 2);
`ifdef CTRL_HALT_EN
    Run = 1'b1;
    repeat (5) @(negedge Clock);
    v = sample();
    checks++;
    if (v !== ctl_t'(22'h1)) begin
      errors++;
      $display("FAIL halt_hold got=%h want=%h", v, ctl_t'(22'h1));
    end
    Run = 1'b0;
`endif

    // Random programs
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 256; i++) begin
        img[i] = {3'($urandom_range(0, 7)), 13'($urandom)};
`ifdef CTRL_HALT_EN
        if (img[i][15:13] == 3'b111) img[i][15:13] = 3'b000;
`endif
      end
      run_burst($sformatf("random%0d", b), 40);
    end

    // Reset during EX2 of add
    clear_img();
    img[0] = 16'h4500;
    mon_en = 1'b0; Run = 1'b0; Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    Run = 1'b1;
    cyc = 0;
    while (!Gin && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    checks++;
    if (!Gin) begin
      errors++;
      $display("FAIL reach_add_ex2 got=%0b want=1", Gin);
    end
    Resetn = 1'b0;
    Run = 1'b0;
    #1;
    v = sample();
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_mid_add got=%h want=%h", v, ctl_t'('0));
    end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge Clock);
      if (sample() !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset active_cycles got=%0d want=0", bad);
    end
    Run = 1'b1;
    @(negedge Clock);
    v = sample();
    checks++;
    if (v !== mk(4'd7, 8'h00, F_INCR | F_ADDR)) begin
      errors++;
      $display("FAIL idle_to_fetch got=%h want=%h", v, mk(4'd7, 8'h00, F_INCR | F_ADDR));
    end
    Run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
